// File: rtl/da2_update_scheduler.sv
// da2_update_scheduler: round-robin sample scheduler for the Pmod DA2 SPI master.
// Holds one 12-bit sample per requester and paces frames with a CS-high gap.
module da2_update_scheduler #(
  parameter int NUM_CH      = 2,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    wr_valid,
  input  logic [NUM_CH*12-1:0] wr_data,
  output logic [NUM_CH-1:0]    pending,
  output logic [NUM_CH-1:0]    done,
  output logic [NUM_CH-1:0]    overrun,
  output logic                 timeout_err,
  output logic [2:0]           active_ch,
  output logic                 spi_start,
  output logic [15:0]          spi_data,
  input  logic                 spi_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WACK  = 3'd2;
  localparam logic [2:0] S_WDONE = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [7:0] GAP_LAST =
    (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [2:0] GAP_EXIT = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  logic [2:0]        state_q, state_d;
  logic [11:0]       hold_q [NUM_CH];
  logic [11:0]       hold_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] ovr_q, ovr_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              start_q, start_d;
  logic [15:0]       data_q, data_d;
  logic [2:0]        act_q, act_d;
  logic [2:0]        rr_q, rr_d;
  logic [7:0]        ack_cnt_q, ack_cnt_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;

  logic              hi_vld, lo_vld, gnt_vld;
  logic [2:0]        hi_idx, lo_idx, gnt_idx;
  logic [11:0]       gnt_smp;
  logic              dispatch;

  // Lowest pending index above rr_q wins; otherwise wrap to lowest overall.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        if (3'(i) > rr_q) begin
          hi_vld = 1'b1;
          hi_idx = 3'(i);
        end else begin
          lo_vld = 1'b1;
          lo_idx = 3'(i);
        end
      end
    end
    gnt_vld = hi_vld | lo_vld;
    gnt_idx = hi_vld ? hi_idx : lo_idx;
    gnt_smp = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (3'(i) == gnt_idx) gnt_smp = hold_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    ovr_d     = ovr_q;
    done_d    = '0;
    tmo_d     = tmo_q;
    start_d   = 1'b0;
    data_d    = data_q;
    act_d     = act_q;
    rr_d      = rr_q;
    ack_cnt_d = ack_cnt_q;
    gap_cnt_d = gap_cnt_q;
    dispatch  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable && gnt_vld) begin
          dispatch = 1'b1;
          data_d   = {4'b0000, gnt_smp};
          act_d    = gnt_idx;
          rr_d     = gnt_idx;
          start_d  = 1'b1;
          state_d  = S_ISSUE;
          for (int i = 0; i < NUM_CH; i++) begin
            if (3'(i) == gnt_idx) pend_d[i] = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        ack_cnt_d = '0;
        state_d   = S_WACK;
      end
      S_WACK: begin
        if (spi_busy) begin
          state_d = S_WDONE;
        end else if (ack_cnt_q >= ACK_LAST) begin
          // Master never answered: put the sample back up for retry.
          tmo_d     = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP_EXIT;
          if (GAP_CYCLES == 0) act_d = '0;
          for (int i = 0; i < NUM_CH; i++) begin
            if (3'(i) == act_q) pend_d[i] = 1'b1;
          end
        end else begin
          ack_cnt_d = ack_cnt_q + 8'd1;
        end
      end
      S_WDONE: begin
        if (!spi_busy) begin
          gap_cnt_d = '0;
          state_d   = GAP_EXIT;
          if (GAP_CYCLES == 0) act_d = '0;
          for (int i = 0; i < NUM_CH; i++) begin
            done_d[i] = (3'(i) == act_q);
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q >= GAP_LAST) begin
          state_d = S_IDLE;
          act_d   = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        act_d   = '0;
      end
    endcase

    // A write on the channel being dispatched this cycle is not an overrun.
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_valid[i]) begin
        hold_d[i] = wr_data[12*i +: 12];
        if (pend_q[i] && !(dispatch && (3'(i) == gnt_idx)))
          ovr_d[i] = 1'b1;
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
      pend_q    <= '0;
      ovr_q     <= '0;
      done_q    <= '0;
      tmo_q     <= 1'b0;
      start_q   <= 1'b0;
      data_q    <= '0;
      act_q     <= '0;
      rr_q      <= '0;
      ack_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      start_q   <= start_d;
      data_q    <= data_d;
      act_q     <= act_d;
      rr_q      <= rr_d;
      ack_cnt_q <= ack_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign pending     = pend_q;
  assign done        = done_q;
  assign overrun     = ovr_q;
  assign timeout_err = tmo_q;
  assign active_ch   = act_q;
  assign spi_start   = start_q;
  assign spi_data    = data_q;

endmodule

// File: tb/tb_da2_update_scheduler.sv
// tb_da2_update_scheduler: directed scenarios plus a randomized phase
// checked against a transaction-level round-robin reference model.
module tb_da2_update_scheduler;

  localparam int NCH  = 2;
  localparam int GAP  = 4;
  localparam int ACKT = 15;
  localparam int LEN  = 40;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b1;
  logic [NCH-1:0]   wr_valid = '0;
  logic [NCH*12-1:0] wr_data = '0;
  logic [NCH-1:0]   pending, done, overrun;
  logic             timeout_err;
  logic [2:0]       active_ch;
  logic             spi_start;
  logic [15:0]      spi_data;
  logic             spi_busy = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  bit   master_ack = 1'b1;
  int   busy_len = LEN;
  int   busy_cnt = 0;
  logic st_seen;

  bit [NCH-1:0] m_pend = '0;
  bit [NCH-1:0] m_ovr = '0;
  logic [11:0]  m_val [NCH];
  int           m_rr = 0;
  bit [NCH-1:0] pw_v = '0;
  logic [11:0]  pw_d [NCH];
  int           n_starts = 0;
  int           n_dones = 0;

  always #5 clk = ~clk;

  da2_update_scheduler #(
    .NUM_CH(NCH), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACKT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .wr_valid(wr_valid), .wr_data(wr_data),
    .pending(pending), .done(done), .overrun(overrun),
    .timeout_err(timeout_err), .active_ch(active_ch),
    .spi_start(spi_start), .spi_data(spi_data),
    .spi_busy(spi_busy)
  );

  // Behavioural SPI master: busy rises one cycle after start, lasts busy_len.
  initial forever begin
    @(negedge clk);
    st_seen = spi_start;
    @(posedge clk);
    #2;
    if (rst) begin
      spi_busy = 1'b0;
      busy_cnt = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) spi_busy = 1'b0;
    end else if (st_seen && master_ack) begin
      spi_busy = 1'b1;
      busy_cnt = busy_len;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (spi_start !== 1'b1 && n < max);
  endtask

  function automatic logic [31:0] outs();
    return 32'({pending, done, overrun, timeout_err,
                active_ch, spi_start, spi_data});
  endfunction

  task automatic model_cycle(input bit gen);
    int  g;
    int  c;
    bit  found;
    tick();
    n_dones += $countones(done);
    if (spi_start === 1'b1) begin
      n_starts++;
      found = 1'b0;
      g = 0;
      for (int k = 1; k <= NCH; k++) begin
        c = (m_rr + k) % NCH;
        if (!found && m_pend[c]) begin
          found = 1'b1;
          g = c;
        end
      end
      chk("rr_has_pending", 32'(found), 32'd1);
      chk("rr_channel", 32'(active_ch), 32'(g));
      chk("rr_data", 32'(spi_data), {20'h0, m_val[g]});
      m_pend[g] = 1'b0;
      m_rr = g;
    end
    for (int i = 0; i < NCH; i++) begin
      if (pw_v[i]) begin
        if (m_pend[i]) m_ovr[i] = 1'b1;
        m_pend[i] = 1'b1;
        m_val[i] = pw_d[i];
      end
    end
    chk("pending_track", 32'(pending), 32'(m_pend));
    wr_valid = '0;
    for (int i = 0; i < NCH; i++) begin
      pw_v[i] = gen && ($urandom_range(0, 15) == 0);
      pw_d[i] = 12'($urandom_range(0, 4095));
      wr_valid[i] = pw_v[i];
      wr_data[12*i +: 12] = pw_d[i];
    end
    busy_len = $urandom_range(1, 12);
  endtask

  initial begin
    int n;
    int cnt_s;
    int cnt_d;
    for (int i = 0; i < NCH; i++) begin
      m_val[i] = '0;
      pw_d[i] = '0;
    end

    // reset state
    repeat (3) tick();
    chk("reset_outputs", outs(), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // single write ch0
    wr_valid = 2'b01;
    wr_data = {12'h000, 12'hABC};
    tick();
    wr_valid = '0;
    chk("t1_pending_load", 32'(pending), 32'd1);
    chk("t1_no_early_start", 32'(spi_start), 32'd0);
    tick();
    chk("t1_start", 32'(spi_start), 32'd1);
    chk("t1_data", 32'(spi_data), 32'h0ABC);
    chk("t1_active", 32'(active_ch), 32'd0);
    chk("t1_pending_clr", 32'(pending), 32'd0);
    repeat (LEN + 1) tick();
    chk("t1_done_early", 32'(done), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd1);
    tick();
    chk("t1_done_1cyc", 32'(done), 32'd0);
    repeat (GAP + 3) tick();
    chk("t1_idle_active", 32'(active_ch), 32'd0);

    // both channels at once: ch1 first, then ch0 after the gap
    wr_valid = 2'b11;
    wr_data = {12'h222, 12'h111};
    tick();
    wr_valid = '0;
    tick();
    chk("t2_first_start", 32'(spi_start), 32'd1);
    chk("t2_first_data", 32'(spi_data), 32'h0222);
    chk("t2_first_ch", 32'(active_ch), 32'd1);
    wait_start(100, n);
    chk("t2_second_start", 32'(spi_start), 32'd1);
    chk("t2_period", 32'(n), 32'(LEN + GAP + 3));
    chk("t2_second_data", 32'(spi_data), 32'h0111);
    chk("t2_second_ch", 32'(active_ch), 32'd0);

    // overrun on ch1 while ch0 in flight
    tick();
    wr_valid = 2'b10; wr_data = {12'h001, 12'h000};
    tick();
    wr_valid = '0;
    tick();
    wr_valid = 2'b10; wr_data = {12'h002, 12'h000};
    tick();
    wr_valid = '0;
    tick();
    wr_valid = 2'b10; wr_data = {12'h003, 12'h000};
    tick();
    wr_valid = '0;
    tick();
    chk("t3_overrun", 32'(overrun), 32'd2);
    chk("t3_pending", 32'(pending), 32'd2);
    wait_start(100, n);
    chk("t3_start", 32'(spi_start), 32'd1);
    chk("t3_latest_data", 32'(spi_data), 32'h0003);
    chk("t3_ch", 32'(active_ch), 32'd1);
    repeat (LEN + GAP + 10) tick();
    chk("t3_drained", 32'(pending), 32'd0);
    wait_start(60, n);
    chk("t3_no_extra", 32'(spi_start), 32'd0);
    chk("t3_overrun_sticky", 32'(overrun), 32'd2);

    // master never acknowledges
    master_ack = 1'b0;
    wr_valid = 2'b01; wr_data = {12'h000, 12'h5A5};
    tick();
    wr_valid = '0;
    tick();
    chk("t4_start", 32'(spi_start), 32'd1);
    repeat (ACKT) tick();
    chk("t4_no_early_tmo", 32'(timeout_err), 32'd0);
    tick();
    chk("t4_timeout", 32'(timeout_err), 32'd1);
    chk("t4_pending_reset", 32'(pending), 32'd1);
    master_ack = 1'b1;
    wait_start(50, n);
    chk("t4_retry_start", 32'(spi_start), 32'd1);
    chk("t4_retry_delay", 32'(n), 32'(GAP + 1));
    chk("t4_retry_data", 32'(spi_data), 32'h05A5);
    repeat (LEN + GAP + 10) tick();
    chk("t4_tmo_sticky", 32'(timeout_err), 32'd1);

    // enable low holds off frames
    enable = 1'b0;
    wr_valid = 2'b01; wr_data = {12'h000, 12'h123};
    tick();
    wr_valid = '0;
    cnt_s = 0;
    repeat (100) begin
      tick();
      if (spi_start === 1'b1) cnt_s++;
    end
    chk("t5_no_start", 32'(cnt_s), 32'd0);
    chk("t5_pending", 32'(pending), 32'd1);
    enable = 1'b1;
    tick();
    chk("t5_start", 32'(spi_start), 32'd1);
    chk("t5_data", 32'(spi_data), 32'h0123);

    // reset during WAIT_DONE
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_async_clear", outs(), 32'd0);
    cnt_d = 0;
    tick();
    cnt_d += $countones(done);
    tick();
    cnt_d += $countones(done);
    chk("t6_held_clear", outs(), 32'd0);
    rst = 1'b0;
    cnt_s = 0;
    repeat (30) begin
      tick();
      if (spi_start === 1'b1) cnt_s++;
      cnt_d += $countones(done);
    end
    chk("t6_no_frame", 32'(cnt_s), 32'd0);
    chk("t6_no_done", 32'(cnt_d), 32'd0);

    // randomized traffic against the reference model
    repeat (3000) model_cycle(1'b1);
    repeat (200) model_cycle(1'b0);
    chk("rand_overrun", 32'(overrun), 32'(m_ovr));
    chk("rand_frames_done", 32'(n_dones), 32'(n_starts));
    chk("rand_some_frames", 32'(n_starts > 10), 32'd1);
    chk("rand_idle", 32'(pending), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
